// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
package fifo_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int SKID_DEPTH  = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: head register drives the stream, tail absorbs one extra word.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [D_WIDTH-1:0] load_data,
  input  logic               pop,
  output occ_t               occupancy,
  output logic [D_WIDTH-1:0] head
);

  logic [D_WIDTH-1:0] tail;
  logic               pop_v;
  logic               empty_after_pop;
  occ_t               occ_n;

  assign pop_v           = pop & (occupancy != OCC_EMPTY);
  assign empty_after_pop = (occupancy == OCC_EMPTY) | ((occupancy == OCC_ONE) & pop_v);

  always_comb begin
    occ_n = occupancy;
    case ({load, pop_v})
      2'b10:   occ_n = (occupancy == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
      2'b01:   occ_n = (occupancy == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      default: occ_n = occupancy;
    endcase
  end

  // A load while TWO is also popping cannot occur: the upstream credit check reserves the slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= OCC_EMPTY;
      head      <= '0;
      tail      <= '0;
    end else begin
      occupancy <= occ_n;
      if (pop_v && (occupancy == OCC_TWO)) head <= tail;
      if (load) begin
        if (empty_after_pop) head <= load_data;
        else                 tail <= load_data;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains fifo_ctrl + RAM into a valid/ready stream through a 2-entry skid buffer.
// Define FIFO_RD_STREAM_CNT_EN to enable the wrapping out_count transfer counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty,
  input  logic [D_WIDTH-1:0]   r_data,
  output logic                 rd,
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] out_count
);

  // Stream handshake: a word transfers on a rising edge where out_valid and out_ready
  // are both 1; out_valid/out_data never change while out_valid=1 and out_ready=0.

  occ_t       occupancy;
  logic [1:0] occ_bits;
  logic       inflight;
  logic       pop;
  logic [2:0] credit_used;

  assign occ_bits    = occupancy;
  assign pop         = out_valid & out_ready;
  assign out_valid   = (occupancy != OCC_EMPTY);
  // Slots already claimed after this cycle's pop: buffered words plus the word still in the RAM.
  assign credit_used = {1'b0, occ_bits} + {2'b00, inflight} - {2'b00, pop};
  assign rd          = reset & ~empty & (credit_used < 3'(SKID_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) inflight <= 1'b0;
    else        inflight <= rd;
  end

  skid_buf2 #(.D_WIDTH(D_WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (inflight),
    .load_data (r_data),
    .pop       (pop),
    .occupancy (occupancy),
    .head      (out_data)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   out_count <= '0;
    else if (pop) out_count <= out_count + 1'b1;
  end
`else
  assign out_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural fifo_ctrl + 1-cycle RAM model.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;
`ifdef FIFO_RD_STREAM_CNT_EN
  localparam logic [CW-1:0] EXP_CNT17 = 4'd1;
`else
  localparam logic [CW-1:0] EXP_CNT17 = 4'd0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          empty;
  logic [DW-1:0] r_data = '0;
  logic          rd;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_count;

  logic [DW-1:0] mem [256];
  int            wr_idx = 0;
  int            rd_idx = 0;
  int            flush_to = 0;
  int            rd_pulses = 0;
  int            pop_cnt = 0;
  int            tests_run = 0;
  int            tests_failed = 0;
  logic [DW-1:0] exp_q [$];

  fifo_rd_stream #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty),
    .r_data    (r_data),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  // Clock / reset-independent infrastructure
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // fifo_ctrl + RAM model: empty follows the pointers, r_data is valid the cycle after rd.
  assign empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (!reset) begin
      rd_idx <= flush_to;
    end else if (rd) begin
      r_data    <= mem[rd_idx];
      rd_idx    <= rd_idx + 1;
      rd_pulses <= rd_pulses + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      check("rd_while_empty", 32'(rd & empty), 32'd0);
      check("land_pop_in_two",
            32'((dut.u_skid.occupancy == OCC_TWO) && dut.inflight && out_valid && out_ready), 32'd0);
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("sb_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        else                   check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end else begin
      pop_cnt = 0;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_idx] = d;
    wr_idx++;
    exp_q.push_back(d);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0;
    int n;

    // Reset held with a non-empty FIFO
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_count", 32'(out_count), 32'd0);
    end
    tick();
    reset = 1'b1;
    #1;
    check("release_rd", 32'(rd), 32'd1);
    out_ready = 1'b1;

    // Three words, latency 2 from rd, then idle
    @(negedge clk); check("lat_t0_valid", 32'(out_valid), 32'd0);
    tick(); @(negedge clk); check("lat_t1_valid", 32'(out_valid), 32'd0);
    tick(); @(negedge clk); check("w0_valid", 32'(out_valid), 32'd1); check("w0_data", 32'(out_data), 32'h11);
    tick(); @(negedge clk); check("w1_valid", 32'(out_valid), 32'd1); check("w1_data", 32'(out_data), 32'h22);
    tick(); @(negedge clk); check("w2_valid", 32'(out_valid), 32'd1); check("w2_data", 32'(out_data), 32'h33);
    tick(); @(negedge clk); check("after_valid", 32'(out_valid), 32'd0);

    // Backpressure: 4 words, consumer stalled
    tick();
    out_ready = 1'b0;
    r0 = rd_pulses;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    push_word(8'hA4);
    repeat (6) tick();
    @(negedge clk);
    check("bp_rd_pulses", 32'(rd_pulses - r0), 32'd2);
    check("bp_occ_two", 32'(dut.u_skid.occupancy), 32'd2);
    check("bp_head", 32'(out_data), 32'hA1);
    check("bp_rd_low", 32'(rd), 32'd0);
    tick(); @(negedge clk);
    check("bp_head_stable", 32'(out_data), 32'hA1);
    check("bp_valid_stable", 32'(out_valid), 32'd1);
    tick();
    out_ready = 1'b1;
    wait_drain(30, "bp_drain");

    // Alternating ready over 16 random words
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_word(DW'($urandom_range(0, 255)));
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      out_ready = ~out_ready;
      tick();
      n++;
    end
    check("alt_drain", 32'(exp_q.size()), 32'd0);
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-stream with a word in flight
    push_word(8'hC1);
    push_word(8'hC2);
    push_word(8'hC3);
    push_word(8'hC4);
    n = 0;
    while (!(dut.inflight && out_valid) && n < 10) begin
      tick();
      n++;
    end
    check("mid_pre_inflight", 32'(dut.inflight & out_valid), 32'd1);
    #2;
    flush_to = wr_idx;
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("mid_async_valid", 32'(out_valid), 32'd0);
    check("mid_async_rd", 32'(rd), 32'd0);
    check("mid_async_data", 32'(out_data), 32'd0);
    check("mid_async_count", 32'(out_count), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(out_valid), 32'd0);
      tick();
    end

    // 17 pops: counter wraps at 16 when enabled, stays 0 otherwise
    for (int i = 0; i < 17; i++) push_word(DW'(8'h40 + i));
    wait_drain(80, "cnt_drain");
    repeat (2) tick();
    @(negedge clk);
    check("cnt_pops", 32'(pop_cnt), 32'd17);
    check("cnt_value", 32'(out_count), 32'(EXP_CNT17));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain stage that sits directly downstream of fifo_ctrl and its storage RAM.
- Pops words through the controller's rd/empty interface and absorbs the RAM's 1-cycle read latency.
- Presents the words as a valid/ready stream to the consumer, buffered in a 2-entry skid buffer.
- Sustains 1 word/cycle while the FIFO is non-empty and the consumer is ready.

Parameters:
- D_WIDTH, 8, data word width; must match the FIFO RAM width.
- CNT_WIDTH, 16, width of the optional transfer counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- empty  in  1  fifo_ctrl empty flag.
- r_data  in  D_WIDTH  RAM read data, valid the cycle after rd=1.
- rd  out  1  pop request to fifo_ctrl (combinational).
- out_data  out  D_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready.
- out_count  out  CNT_WIDTH  transferred-word count (only with FIFO_RD_STREAM_CNT_EN).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
  - Port clk; port reset is asserted at 0.
  - All flops clear immediately when reset=0, independent of clk.
- Reset values:
  - rd=0 (forced low while reset=0), out_valid=0, out_data=0, out_count=0.
  - Internal occupancy=0, inflight=0.
- Transfer: a stream word moves on a rising edge where out_valid=1 and out_ready=1 (pop).
- Occupancy FSM: states EMPTY(0), ONE(1), TWO(2); plus an inflight flag = rd was 1 in the previous cycle.
  - pop decrements occupancy.
  - inflight landing increments it.
  - Both in one cycle leaves occupancy unchanged.
- rd rule (combinational): rd = ~empty & reset & (occupancy + inflight - pop < 2).
  - This never overflows the buffer.
  - Steady state is ONE + inflight with one pop every cycle.
- Data path:
  - r_data is captured on the edge ending the cycle after rd=1.
  - If occupancy after pop is 0, the word goes to the head register, else to the tail register.
  - On pop with TWO, tail moves to head.
- out_valid = (occupancy != 0). out_data = head register.
  - Both hold stable while out_valid=1 and out_ready=0.
- Latency: empty falls in cycle t with the buffer idle → rd=1 in cycle t, out_valid=1 in cycle t+2.
- Empty FIFO: rd=0 regardless of credit. empty is sampled each cycle; fifo_ctrl updates it on the same edge that consumes rd.
- Backpressure:
  - out_ready=0 with TWO → rd=0.
  - Inflight data is never dropped; the credit rule reserves its slot.
- Simultaneous inflight landing and pop in TWO: impossible by the credit rule. The bench asserts it never happens.
- Reset mid-operation:
  - All buffered and inflight words are discarded.
  - fifo_ctrl is reset together with this block, so no pointer mismatch occurs.

Optional Feature:
- Macro FIFO_RD_STREAM_CNT_EN.
- Defined:
  - out_count increments by 1 on every pop.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Cleared by reset.
- Undefined:
  - out_count is tied to 0.
  - The counter flops are not instantiated.
  - Port list is unchanged.

Decomposition:
- Package fifo_pkg holds:
  - typedef occ_t (2-bit enum OCC_EMPTY/OCC_ONE/OCC_TWO);
  - localparam SKID_DEPTH=2;
  - the shared D_WIDTH default.
- Sub-module skid_buf2: holds head/tail registers and occupancy.
  - Inputs: load, load_data, pop.
  - Outputs: occupancy, head.
- fifo_rd_stream adds the rd credit logic, inflight flag and optional counter.

Test Plan:
- Reset with empty=0, reset=0 held 3 cycles → rd=0, out_valid=0, out_data=0 throughout; release → rd=1 the same cycle.
- FIFO holds 0x11,0x22,0x33, out_ready=1 → out_valid high 3 consecutive cycles with data 0x11,0x22,0x33; first word 2 cycles after rd; then out_valid=0.
- 4 words, out_ready=0 → exactly 2 rd pulses, occupancy TWO, out_data=first word stable; raise out_ready → remaining words follow in order, no loss or duplication.
- Alternate out_ready 1/0 over 16 random words → output sequence equals input sequence; rd never high while empty=1.
- Assert reset=0 mid-stream with inflight=1 → out_valid=0 on that cycle asynchronously; no stale word appears after release.
- With FIFO_RD_STREAM_CNT_EN and CNT_WIDTH=4: 17 pops → out_count=1 (wrap); without the macro → out_count=0.
